// File: rtl/frame_write_burst_gen.sv
// rtl/frame_write_burst_gen.sv - splits each frame into FIFO-gated write bursts on a valid/ready command port
module frame_write_burst_gen #(
    parameter int ADDR_BITS   = 25,
    parameter int BURST_LEN   = 64,
    parameter int LEN_BITS    = 7,
    parameter int CNT_BITS    = 10,
    parameter int FRAME_WORDS = 129600,
    parameter int ADDR_STEP   = 1
) (
    input  logic                 write_clk,
    input  logic                 write_rst_n,
    input  logic                 enable,
    input  logic                 write_vs,
    input  logic [ADDR_BITS-1:0] write_base,
    input  logic [CNT_BITS-1:0]  fifo_level,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 burst_done,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DATA,
        S_DONE
    } state_e;

    localparam logic [ADDR_BITS-1:0] FRAME_W = ADDR_BITS'(FRAME_WORDS);
    localparam logic [ADDR_BITS-1:0] BURST_W = ADDR_BITS'(BURST_LEN);

    state_e                 state_q, state_d;
    logic                   vs_q;
    logic                   vs_rise;
    logic                   mid_frame;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [ADDR_BITS-1:0]   left_q, left_d;
    logic [ADDR_BITS-1:0]   pend_base_q, pend_base_d;
    logic                   pend_q, pend_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [ADDR_BITS-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LEN_BITS-1:0]    cmd_len_q, cmd_len_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic [LEN_BITS-1:0]    len_w;
    logic                   fifo_ok;
    logic [ADDR_BITS-1:0]   step_w;

    assign vs_rise   = write_vs & ~vs_q;
    assign mid_frame = (state_q == S_CHECK) || (state_q == S_REQ) || (state_q == S_DATA);
    assign len_w     = (left_q < BURST_W) ? left_q[LEN_BITS-1:0] : LEN_BITS'(BURST_LEN);
    assign fifo_ok   = 32'(fifo_level) >= 32'(len_w);
    assign step_w    = ADDR_BITS'(32'(cmd_len_q) * 32'(ADDR_STEP));

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending restart is consumed in CHECK before any further burst is issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (vs_rise || pend_q)) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!enable)                state_d = S_IDLE;
                else if (pend_q)            state_d = S_CHECK;
                else if (left_q == '0)      state_d = S_DONE;
                else if (fifo_ok)           state_d = S_REQ;
            end
            S_REQ: begin
                if (cmd_ready) state_d = S_DATA;
            end
            S_DATA: begin
                if (burst_done) state_d = S_CHECK;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        left_d       = left_q;
        pend_d       = pend_q;
        pend_base_d  = pend_base_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        frame_err_d  = 1'b0;
        frame_done_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
        if (vs_rise && (mid_frame || state_q == S_DONE)) begin
            pend_d      = 1'b1;
            pend_base_d = write_base;
            frame_err_d = mid_frame;
        end
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (enable && vs_rise) begin
                    addr_d = write_base;
                    left_d = FRAME_W;
                end else if (enable && pend_q) begin
                    addr_d = pend_base_q;
                    left_d = FRAME_W;
                end
            end
            S_CHECK: begin
                if (!enable) begin
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    addr_d = pend_base_q;
                    left_d = FRAME_W;
                    if (!vs_rise) pend_d = 1'b0;
                end else if (left_q != '0 && fifo_ok) begin
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = addr_q;
                    cmd_len_d   = len_w;
                end
            end
            S_REQ: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    addr_d      = addr_q + step_w;
                    left_d      = left_q - ADDR_BITS'(cmd_len_q);
                end
            end
            default: ;
        endcase
    end

    // vs_q resets high so a sync already asserted at reset release is not taken as an edge.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            vs_q         <= 1'b1;
            addr_q       <= '0;
            left_q       <= '0;
            pend_q       <= 1'b0;
            pend_base_q  <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            vs_q         <= write_vs;
            addr_q       <= addr_d;
            left_q       <= left_d;
            pend_q       <= pend_d;
            pend_base_q  <= pend_base_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_len    = cmd_len_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
